// File: rtl/wb_intercon.sv
// wb_intercon: Wishbone B4 classic NM-master / NS-slave interconnect.
// Round-robin arbiter, base/mask decode, error termination + bus-error irq.
//
// Optional feature macro: WB_TIMEOUT_EN (stalled-slave timeout counter).
//
// Ports:
//   wb_clk_i, wb_rstn_i        clock, async active-low reset
//   m_adr_i/m_dat_i/m_sel_i    packed per-master request fields
//   m_we_i/m_stb_i/m_cyc_i     per-master control
//   m_dat_o/m_ack_o/m_err_o    read data (broadcast), per-master ack/err
//   s_adr_o/s_dat_o/s_sel_o    shared slave request fields
//   s_we_o/s_cyc_o/s_stb_o     shared we, per-slave cyc/stb
//   s_dat_i/s_ack_i            packed slave read data, slave acks
//   berr_irq_o/berr_adr_o      error pulse and last error address
module wb_intercon #(
    parameter int              NM       = 2,
    parameter int              NS       = 8,
    parameter logic [NS*32-1:0] SLV_BASE = '0,
    parameter logic [NS*32-1:0] SLV_MASK = '0,
    parameter int              TIMEOUT  = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rstn_i,
    input  logic [NM*32-1:0] m_adr_i,
    input  logic [NM*32-1:0] m_dat_i,
    input  logic [NM*4-1:0]  m_sel_i,
    input  logic [NM-1:0]    m_we_i,
    input  logic [NM-1:0]    m_stb_i,
    input  logic [NM-1:0]    m_cyc_i,
    output logic [31:0]      m_dat_o,
    output logic [NM-1:0]    m_ack_o,
    output logic [NM-1:0]    m_err_o,
    output logic [31:0]      s_adr_o,
    output logic [31:0]      s_dat_o,
    output logic [3:0]       s_sel_o,
    output logic             s_we_o,
    output logic [NS-1:0]    s_cyc_o,
    output logic [NS-1:0]    s_stb_o,
    input  logic [NS*32-1:0] s_dat_i,
    input  logic [NS-1:0]    s_ack_i,
    output logic             berr_irq_o,
    output logic [31:0]      berr_adr_o
);

    localparam int MW = (NM > 1) ? $clog2(NM) : 1;
    localparam int SW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t        state;
    logic [MW-1:0] gnt;
    logic [MW-1:0] last;
    logic [MW-1:0] win;
    logic [MW-1:0] idx;
    logic          err_q;
    logic          err_set;
    logic          to_err;

    logic          own;
    logic          cyc_g;
    logic          stb_g;
    logic          we_g;
    logic [31:0]   adr_g;
    logic [31:0]   dat_g;
    logic [3:0]    sel_g;

    logic          hit;
    logic [SW-1:0] sel;
    logic          ack_raw;

    assign own   = (state == OWN);
    assign cyc_g = m_cyc_i[gnt];
    assign stb_g = m_stb_i[gnt];
    assign we_g  = m_we_i[gnt];
    assign adr_g = m_adr_i[gnt*32 +: 32];
    assign dat_g = m_dat_i[gnt*32 +: 32];
    assign sel_g = m_sel_i[gnt*4 +: 4];

    // Search downward so the requester closest after 'last' wins.
    always_comb begin
        win = last;
        idx = '0;
        for (int k = NM; k >= 1; k--) begin
            idx = MW'((int'(last) + k) % NM);
            if (m_cyc_i[idx]) win = idx;
        end
    end

    // Descending scan: lowest matching slave index has priority.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if ((adr_g & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
                hit = 1'b1;
                sel = SW'(i);
            end
        end
    end

    assign ack_raw = hit & s_ack_i[sel];

    assign err_set = own & cyc_g & stb_g & ~err_q & (~hit | to_err);

`ifdef WB_TIMEOUT_EN
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT - 1);

    logic [15:0] to_cnt;

    assign to_err = hit & ~ack_raw & (to_cnt == TO_LIM);

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            to_cnt <= '0;
        end else if (!own || !stb_g || ack_raw || err_set) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 16'd1;
        end
    end
`else
    logic [31:0] to_unused;

    assign to_unused = TIMEOUT;
    assign to_err    = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state      <= IDLE;
            gnt        <= '0;
            last       <= MW'(NM - 1);
            err_q      <= 1'b0;
            berr_adr_o <= '0;
        end else begin
            err_q <= err_set;
            if (err_set) berr_adr_o <= adr_g;
            unique case (state)
                IDLE: begin
                    if (|m_cyc_i) begin
                        state <= OWN;
                        gnt   <= win;
                        last  <= win;
                    end
                end
                OWN: begin
                    if (!cyc_g) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign berr_irq_o = err_q;

    always_comb begin
        s_adr_o = own ? adr_g : '0;
        s_dat_o = own ? dat_g : '0;
        s_sel_o = own ? sel_g : '0;
        s_we_o  = own & we_g;
        s_cyc_o = '0;
        s_stb_o = '0;
        m_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        if (own && hit) begin
            s_cyc_o[sel] = cyc_g;
            s_stb_o[sel] = stb_g;
            m_dat_o      = s_dat_i[sel*32 +: 32];
            // A timeout err cycle keeps stb up; suppress a late ack there.
            m_ack_o[gnt] = stb_g & ack_raw & ~err_q;
        end
        m_err_o[gnt] = err_q;
    end

endmodule

// File: tb/tb_wb_intercon.sv
// tb_wb_intercon: directed bench for wb_intercon (NM=2, NS=8).
// Two instances share stimulus: table A (no catch-all) and B (slave 5 catch-all).
module tb_wb_intercon;

    localparam logic [255:0] BASE_A = {
        32'h1, 32'h1, 32'h1, 32'h1,
        32'hF000_0000, 32'h2000_0000, 32'h1, 32'h0
    };
    localparam logic [255:0] MASK_A = {
        32'h0, 32'h0, 32'h0, 32'h0,
        32'hF000_0000, 32'hF000_0000, 32'h0, 32'hFFFF_E000
    };
    localparam logic [255:0] BASE_B = {
        32'h1, 32'h1, 32'h0, 32'h1,
        32'hF000_0000, 32'h2000_0000, 32'h1, 32'h0
    };
    localparam logic [255:0] MASK_B = MASK_A;

    logic         clk = 1'b0;
    logic         rstn;
    logic [63:0]  m_adr;
    logic [63:0]  m_dat;
    logic [7:0]   m_sel;
    logic [1:0]   m_we;
    logic [1:0]   m_stb;
    logic [1:0]   m_cyc;
    logic [255:0] s_dat;
    logic [7:0]   s_ack;

    logic [31:0]  a_mdat, b_mdat;
    logic [1:0]   a_mack, b_mack;
    logic [1:0]   a_merr, b_merr;
    logic [31:0]  a_sadr, b_sadr;
    logic [31:0]  a_sdat, b_sdat;
    logic [3:0]   a_ssel, b_ssel;
    logic         a_swe, b_swe;
    logic [7:0]   a_scyc, b_scyc;
    logic [7:0]   a_sstb, b_sstb;
    logic         a_irq, b_irq;
    logic [31:0]  a_badr, b_badr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_intercon #(
        .NM(2), .NS(8), .SLV_BASE(BASE_A), .SLV_MASK(MASK_A), .TIMEOUT(4)
    ) u_dut (
        .wb_clk_i(clk), .wb_rstn_i(rstn),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_we_i(m_we), .m_stb_i(m_stb), .m_cyc_i(m_cyc),
        .m_dat_o(a_mdat), .m_ack_o(a_mack), .m_err_o(a_merr),
        .s_adr_o(a_sadr), .s_dat_o(a_sdat), .s_sel_o(a_ssel),
        .s_we_o(a_swe), .s_cyc_o(a_scyc), .s_stb_o(a_sstb),
        .s_dat_i(s_dat), .s_ack_i(s_ack),
        .berr_irq_o(a_irq), .berr_adr_o(a_badr)
    );

    wb_intercon #(
        .NM(2), .NS(8), .SLV_BASE(BASE_B), .SLV_MASK(MASK_B), .TIMEOUT(4)
    ) u_ovl (
        .wb_clk_i(clk), .wb_rstn_i(rstn),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_we_i(m_we), .m_stb_i(m_stb), .m_cyc_i(m_cyc),
        .m_dat_o(b_mdat), .m_ack_o(b_mack), .m_err_o(b_merr),
        .s_adr_o(b_sadr), .s_dat_o(b_sdat), .s_sel_o(b_ssel),
        .s_we_o(b_swe), .s_cyc_o(b_scyc), .s_stb_o(b_sstb),
        .s_dat_i(s_dat), .s_ack_i(s_ack),
        .berr_irq_o(b_irq), .berr_adr_o(b_badr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic idle_m;
        m_cyc = '0;
        m_stb = '0;
        m_we  = '0;
        m_sel = '0;
        m_adr = '0;
        m_dat = '0;
    endtask

    task automatic test_reset;
        rstn  = 1'b0;
        idle_m();
        s_ack = '0;
        s_dat = '0;
        #3;
        total++;
        if ({a_sstb, a_scyc, a_mack, a_merr, a_irq} !== 21'h0) begin
            bad++;
            $display("FAIL reset_ctl got %h want 0",
                     {a_sstb, a_scyc, a_mack, a_merr, a_irq});
        end
        total++;
        if (a_badr !== 32'h0) begin
            bad++;
            $display("FAIL reset_badr got %h want 0", a_badr);
        end
        m_adr[31:0] = 32'h2000_0000;
        m_cyc = 2'b01;
        m_stb = 2'b01;
        tick();
        total++;
        if (a_sstb !== 8'h00 || a_sadr !== 32'h0) begin
            bad++;
            $display("FAIL reset_hold got stb=%h adr=%h want 0", a_sstb, a_sadr);
        end
        idle_m();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_round_robin;
        m_adr = {32'h2000_0020, 32'h2000_0010};
        m_cyc = 2'b11;
        m_stb = 2'b11;
        settle();
        total++;
        if (a_sstb !== 8'h00) begin
            bad++;
            $display("FAIL rr_latency got %h want 00", a_sstb);
        end
        for (int k = 0; k < 4; k++) begin
            int e;
            logic [31:0] want;
            e = k % 2;
            want = (e == 0) ? 32'h2000_0010 : 32'h2000_0020;
            tick();
            total++;
            if (a_sadr !== want || a_sstb !== 8'h04) begin
                bad++;
                $display("FAIL rr_owner%0d got adr=%h stb=%h want adr=%h stb=04",
                         k, a_sadr, a_sstb, want);
            end
            m_cyc[e] = 1'b0;
            m_stb[e] = 1'b0;
            tick();
            total++;
            if (a_sstb !== 8'h00) begin
                bad++;
                $display("FAIL rr_gap%0d got %h want 00", k, a_sstb);
            end
            m_cyc[e] = 1'b1;
            m_stb[e] = 1'b1;
        end
        idle_m();
        tick();
    endtask

    task automatic test_read_hit;
        m_adr[31:0] = 32'hF000_0004;
        m_sel = 8'h0F;
        m_cyc = 2'b01;
        m_stb = 2'b01;
        s_dat[127:96] = 32'h1234_5678;
        tick();
        total++;
        if (a_sstb !== 8'h08 || a_scyc !== 8'h08) begin
            bad++;
            $display("FAIL hit_stb got stb=%h cyc=%h want 08", a_sstb, a_scyc);
        end
        total++;
        if (a_mack !== 2'b00) begin
            bad++;
            $display("FAIL hit_noack got %b want 00", a_mack);
        end
        s_ack = 8'h08;
        settle();
        total++;
        if (a_mack !== 2'b01 || a_mdat !== 32'h1234_5678) begin
            bad++;
            $display("FAIL hit_ack got ack=%b dat=%h want 01 12345678",
                     a_mack, a_mdat);
        end
        tick();
        s_ack = '0;
        idle_m();
        settle();
        total++;
        if (a_mack !== 2'b00) begin
            bad++;
            $display("FAIL hit_ackdrop got %b want 00", a_mack);
        end
        tick();
    endtask

    task automatic test_write_m1;
        m_adr[63:32] = 32'h2000_0008;
        m_dat[63:32] = 32'hCAFE_BABE;
        m_sel[7:4] = 4'b0011;
        m_we  = 2'b10;
        m_cyc = 2'b10;
        m_stb = 2'b10;
        tick();
        total++;
        if (a_sadr !== 32'h2000_0008 || a_sdat !== 32'hCAFE_BABE ||
            a_ssel !== 4'b0011 || a_swe !== 1'b1 || a_sstb !== 8'h04) begin
            bad++;
            $display("FAIL wr_fields got %h %h %h %b %h want 20000008 cafebabe 3 1 04",
                     a_sadr, a_sdat, a_ssel, a_swe, a_sstb);
        end
        s_ack = 8'h04;
        settle();
        total++;
        if (a_mack !== 2'b10) begin
            bad++;
            $display("FAIL wr_ack_m1 got %b want 10", a_mack);
        end
        tick();
        s_ack = '0;
        idle_m();
        tick();
    endtask

    task automatic test_overlap;
        m_adr[31:0] = 32'h0000_0100;
        m_cyc = 2'b01;
        m_stb = 2'b01;
        s_dat[31:0] = 32'hA5A5_0100;
        tick();
        total++;
        if (b_sstb !== 8'h01 || a_sstb !== 8'h01) begin
            bad++;
            $display("FAIL ovl_stb got b=%h a=%h want 01", b_sstb, a_sstb);
        end
        s_ack = 8'h01;
        settle();
        total++;
        if (b_mdat !== 32'hA5A5_0100 || b_mack !== 2'b01) begin
            bad++;
            $display("FAIL ovl_data got %h ack=%b want a5a50100 01", b_mdat, b_mack);
        end
        tick();
        s_ack = '0;
        idle_m();
        tick();
    endtask

    task automatic test_unmapped;
        m_adr[31:0] = 32'h9000_0000;
        m_cyc = 2'b01;
        m_stb = 2'b01;
        tick();
        total++;
        if (a_sstb !== 8'h00 || a_merr !== 2'b00 || a_irq !== 1'b0) begin
            bad++;
            $display("FAIL unm_first got stb=%h err=%b irq=%b want 0",
                     a_sstb, a_merr, a_irq);
        end
        total++;
        if (b_sstb !== 8'h20) begin
            bad++;
            $display("FAIL unm_catchall got %h want 20", b_sstb);
        end
        tick();
        total++;
        if (a_merr !== 2'b01 || a_irq !== 1'b1 || a_mack !== 2'b00) begin
            bad++;
            $display("FAIL unm_err got err=%b irq=%b ack=%b want 01 1 00",
                     a_merr, a_irq, a_mack);
        end
        total++;
        if (a_badr !== 32'h9000_0000) begin
            bad++;
            $display("FAIL unm_badr got %h want 90000000", a_badr);
        end
        tick();
        total++;
        if (a_merr !== 2'b00 || a_irq !== 1'b0) begin
            bad++;
            $display("FAIL unm_gap got err=%b irq=%b want 00 0", a_merr, a_irq);
        end
        idle_m();
        tick();
        total++;
        if (a_merr !== 2'b00 || a_badr !== 32'h9000_0000) begin
            bad++;
            $display("FAIL unm_after got err=%b badr=%h want 00 90000000",
                     a_merr, a_badr);
        end
    endtask

`ifdef WB_TIMEOUT_EN
    task automatic test_timeout;
        m_adr[31:0] = 32'h2000_0000;
        m_cyc = 2'b01;
        m_stb = 2'b01;
        tick();
        for (int k = 2; k <= 4; k++) begin
            tick();
            total++;
            if (a_merr !== 2'b00) begin
                bad++;
                $display("FAIL to_early%0d got %b want 00", k, a_merr);
            end
        end
        tick();
        total++;
        if (a_merr !== 2'b01 || a_irq !== 1'b1 || a_sstb !== 8'h04) begin
            bad++;
            $display("FAIL to_err got err=%b irq=%b stb=%h want 01 1 04",
                     a_merr, a_irq, a_sstb);
        end
        total++;
        if (a_badr !== 32'h2000_0000) begin
            bad++;
            $display("FAIL to_badr got %h want 20000000", a_badr);
        end
        idle_m();
        tick();
        tick();
        m_adr[31:0] = 32'h2000_0000;
        m_cyc = 2'b01;
        m_stb = 2'b01;
        tick();
        tick();
        tick();
        tick();
        s_ack = 8'h04;
        settle();
        total++;
        if (a_mack !== 2'b01) begin
            bad++;
            $display("FAIL to_lateack got %b want 01", a_mack);
        end
        tick();
        total++;
        if (a_merr !== 2'b00 || a_irq !== 1'b0) begin
            bad++;
            $display("FAIL to_ackwins got err=%b irq=%b want 00 0", a_merr, a_irq);
        end
        s_ack = '0;
        idle_m();
        tick();
        tick();
    endtask
`else
    task automatic test_stall_hang;
        m_adr[31:0] = 32'h2000_0000;
        m_cyc = 2'b01;
        m_stb = 2'b01;
        tick();
        for (int k = 0; k < 20; k++) begin
            tick();
            total++;
            if (a_merr !== 2'b00 || a_sstb !== 8'h04) begin
                bad++;
                $display("FAIL hang%0d got err=%b stb=%h want 00 04",
                         k, a_merr, a_sstb);
            end
        end
        idle_m();
        tick();
        tick();
    endtask
`endif

    task automatic test_reset_mid;
        m_adr = {32'h2000_0044, 32'h2000_0004};
        m_cyc = 2'b01;
        m_stb = 2'b01;
        tick();
        total++;
        if (a_sstb !== 8'h04) begin
            bad++;
            $display("FAIL rm_pre got %h want 04", a_sstb);
        end
        #2;
        rstn  = 1'b0;
        s_ack = 8'h04;
        #1;
        total++;
        if (a_sstb !== 8'h00 || a_scyc !== 8'h00 || a_mack !== 2'b00) begin
            bad++;
            $display("FAIL rm_async got stb=%h cyc=%h ack=%b want 0",
                     a_sstb, a_scyc, a_mack);
        end
        m_cyc = 2'b11;
        m_stb = 2'b11;
        tick();
        total++;
        if (a_merr !== 2'b00 || a_sstb !== 8'h00) begin
            bad++;
            $display("FAIL rm_held got err=%b stb=%h want 0", a_merr, a_sstb);
        end
        rstn = 1'b1;
        tick();
        total++;
        if (a_sadr !== 32'h2000_0004 || a_mack !== 2'b01) begin
            bad++;
            $display("FAIL rm_first got adr=%h ack=%b want 20000004 01",
                     a_sadr, a_mack);
        end
        s_ack = '0;
        idle_m();
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_read_hit();
        test_write_m1();
        test_overlap();
        test_unmapped();
`ifdef WB_TIMEOUT_EN
        test_timeout();
`else
        test_stall_hang();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
